// File: rtl/neuron_preact_if.sv
// Handshake bundle between the activation/weight source, the pre-activation
// block and the downstream sigmoid stage.
`timescale 1ns/1ps
interface neuron_preact_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a;
  logic signed [15:0] w;
  logic signed [31:0] bias;
  logic               out_valid;
  logic               out_ready;
  logic        [31:0] x;

  // Pre-activation block side.
  modport slave (
    input  in_valid, a, w, bias, out_ready,
    output in_ready, out_valid, x
  );

  // Upstream source / downstream sink side.
  modport master (
    output in_valid, a, w, bias, out_ready,
    input  in_ready, out_valid, x
  );
endinterface

// File: rtl/neuron_preact.sv
// Neuron pre-activation: bias + sum of LEN Q8.8 products, accumulated in
// Q16.16 on 40 bits, then converted (truncating) to IEEE-754 single.
`timescale 1ns/1ps
module neuron_preact #(
  parameter int LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  neuron_preact_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, CONV, OUT} state_t;

  state_t             state_reg, state_next;
  logic signed [39:0] acc_reg, acc_next;
  logic        [7:0]  count_reg, count_next;
  logic        [31:0] x_reg, x_next;
  logic               out_valid_reg, out_valid_next;

  logic signed [31:0] prod;
  logic               accept;
  logic               last_beat;
  logic        [39:0] mag;
  logic        [5:0]  lead;
  logic        [22:0] mant;
  logic        [31:0] fp_bits;

  assign bus.in_ready  = (state_reg == IDLE) || (state_reg == ACCUM);
  assign bus.out_valid = out_valid_reg;
  assign bus.x         = x_reg;

  assign prod      = bus.a * bus.w;
  assign accept    = bus.in_valid && bus.in_ready;
  // In IDLE count_reg is 0, so this also covers the LEN=1 first-beat case.
  assign last_beat = ({1'b0, count_reg} + 9'd1) == 9'(LEN);

  // Magnitude, leading-one position and truncated mantissa of the accumulator.
  always_comb begin
    mag  = acc_reg[39] ? 40'(-acc_reg) : 40'(acc_reg);
    lead = '0;
    for (int i = 0; i < 40; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    // Left-align the leading one to bit 39; the 23 bits below it form the mantissa.
    mant = 23'((mag << (6'd39 - lead)) >> 16);
    if (mag == '0)
      fp_bits = 32'h0000_0000;
    else
      fp_bits = {acc_reg[39], 8'(8'd111 + {2'b00, lead}), mant};
  end

  // Next-state and datapath updates for the IDLE/ACCUM/CONV/OUT controller.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    x_next         = x_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          acc_next   = 40'(bus.bias) + 40'(prod);
          count_next = 8'd1;
          state_next = last_beat ? CONV : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_next   = acc_reg + 40'(prod);
          count_next = count_reg + 8'd1;
          if (last_beat) state_next = CONV;
        end
      end
      CONV: begin
        x_next         = fp_bits;
        out_valid_next = 1'b1;
        count_next     = '0;
        state_next     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset discards any partial dot product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      x_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      x_reg         <= x_next;
      out_valid_reg <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_neuron_preact.sv
// Directed bench for neuron_preact (LEN=4) with hand-computed float results.
`timescale 1ns/1ps
module tb_neuron_preact;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neuron_preact_if bus();

  neuron_preact #(.LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one beat and let it be accepted on the next rising edge.
  task automatic beat(input logic [15:0] av, input logic [15:0] wv, input logic [31:0] bv);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.w        = wv;
    bus.bias     = bv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.w        = '0;
    bus.bias     = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full transaction: 4 beats (beat i uses slice i, gap i idle cycles first),
  // latency check, result check, handshake and retention check.
  task automatic run_vec(input string tag, input logic [63:0] av, input logic [63:0] wv,
                         input logic [31:0] bv, input logic [15:0] gaps, input logic [31:0] exp);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(int'(gaps[4*i +: 4]));
      beat(av[16*i +: 16], wv[16*i +: 16], bv);
    end
    check({tag, " conv_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " x"}, bus.x, exp);
    $display("vec %s: x=%h (want %h)", tag, bus.x, exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " done_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " done_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, " x_hold"}, bus.x, exp);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.w         = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;   // ignored outside OUT
    #12;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst x", bus.x, 32'h0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    run_vec("ones4",  64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 32'h0, 16'h0000, 32'h4080_0000);
    run_vec("bias-7", 64'h0, 64'h0100_0100_0100_0100, 32'hFFF9_0000, 16'h0000, 32'hC0E0_0000);
    run_vec("half",   64'h0000_0000_0000_0080, 64'h0000_0000_0000_0100, 32'h0, 16'h0000, 32'h3F00_0000);
    run_vec("lsb",    64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 32'h0, 16'h0000, 32'h3780_0000);
    run_vec("zero",   64'h0, 64'h0, 32'h0, 16'h0000, 32'h0000_0000);
    run_vec("gaps",   64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 32'h0, 16'h3210, 32'h4080_0000);
    // -1.5 + 1.0 + 1.0 + 3.0 + bias 1.0 = 4.5
    run_vec("mixed",  64'h0300_0040_0200_0180, 64'h0100_0400_0080_FF00, 32'h0001_0000, 16'h1021, 32'h4090_0000);
    // 0x7FFFFFFF needs 31 significant bits: mantissa truncated, not rounded.
    run_vec("trunc",  64'h0, 64'h0, 32'h7FFF_FFFF, 16'h0000, 32'h46FF_FFFF);
    run_vec("minb",   64'h0, 64'h0, 32'h8000_0000, 16'h0000, 32'hC700_0000);
    // 4 x (-128 * -128) = 2^32 needs more than 32 accumulator bits.
    run_vec("wide",   64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 32'h0, 16'h0000, 32'h4780_0000);

    // Back-pressure: hold in OUT with in_valid asserted.
    for (int i = 0; i < 4; i++) beat(16'h0100, 16'h0100, 32'h0);
    @(posedge clk); #1;
    check("stall out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = 16'h7F00;
    bus.w        = 16'h7F00;
    bus.bias     = 32'h1234_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall x", bus.x, 32'h4080_0000);
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      check("stall valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.w         = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("stall release valid", 32'(bus.out_valid), 32'd0);
    check("stall release ready", 32'(bus.in_ready), 32'd1);
    $display("vec stall: x=%h after 5 held cycles", bus.x);
    run_vec("poststall", 64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 32'h0, 16'h0000, 32'h4080_0000);

    // Reset after 2 of 4 beats; x is nonzero beforehand.
    beat(16'h0100, 16'h0100, 32'h0);
    beat(16'h0100, 16'h0100, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst x", bus.x, 32'h0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    $display("vec midrst: reset after 2 beats");
    run_vec("afterrst", 64'h0200_0200_0200_0200, 64'h0100_0100_0100_0100, 32'h0, 16'h0000, 32'h4100_0000);

    // Reset while holding a result in OUT.
    for (int i = 0; i < 4; i++) beat(16'h0100, 16'h0100, 32'h0);
    @(posedge clk); #1;
    check("outrst pre valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("outrst out_valid", 32'(bus.out_valid), 32'd0);
    check("outrst x", bus.x, 32'h0);
    check("outrst in_ready", 32'(bus.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    $display("vec outrst: reset while in OUT");
    run_vec("afterrst2", 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0100, 32'h0, 16'h0000, 32'h3F00_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_preact.md
NEURON_PREACT -- requirements
Module: neuron_preact

Interface
REQ-001 Parameter LEN, default 4, number of multiply terms per dot product; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  the current a/w/bias beat is valid.
REQ-005 in_ready  output  1  the block accepts a beat this cycle.
REQ-006 a  input  16  signed Q8.8 activation.
REQ-007 w  input  16  signed Q8.8 weight.
REQ-008 bias  input  32  signed Q16.16 bias; sampled only on the first beat of a dot product.
REQ-009 out_valid  output  1  x holds a completed pre-activation.
REQ-010 out_ready  input  1  the downstream sigmoid stage accepts x.
REQ-011 x  output  32  IEEE-754 single-precision pre-activation, the input to the downstream sigmoid stage.

Function
REQ-012 The block SHALL compute x = float(bias + sum over LEN beats of a*w), with the product a*w taken as a signed 32-bit Q16.16 value.
REQ-013 The accumulator SHALL be 40-bit signed, wide enough that no overflow occurs for legal LEN.
REQ-014 The FSM SHALL have four states: IDLE, ACCUM, CONV and OUT.
REQ-015 IDLE and ACCUM: in_ready=1. CONV and OUT: in_ready=0.
REQ-016 A beat is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 First beat accepted in IDLE: acc <= sext(bias) + a*w, count <= 1, next state ACCUM, or CONV if LEN=1.
REQ-018 Beat accepted in ACCUM: acc <= acc + a*w, count++; the beat that makes count=LEN moves the FSM to CONV.
REQ-019 in_valid=0 in IDLE or ACCUM SHALL hold all state; gaps between beats are legal.
REQ-020 CONV lasts exactly one cycle, with the following behaviour:
- take the 40-bit magnitude |acc| and sign s;
- let p = bit index of the leading one;
- register x = {s, 8'(127+p-16), next 23 bits below p, left-aligned and zero-padded, truncated with no rounding};
- set out_valid <= 1 and move to OUT.
REQ-021 acc = 0 SHALL produce x = 32'h00000000, a positive zero.
REQ-022 Latency: last beat accepted at edge E -> x valid and out_valid=1 after edge E+1.
REQ-023 OUT: x and out_valid SHALL hold stable until an edge with out_ready=1; on that edge out_valid <= 0 and the FSM returns to IDLE.
REQ-024 out_ready while not in OUT SHALL be ignored.
REQ-025 in_valid while in CONV or OUT SHALL be ignored; the beat is not consumed, because in_ready=0.
REQ-026 x SHALL retain its last value after the handshake until the next CONV.

Reset
REQ-027 rst_n=0 at any time, including mid-accumulation or in OUT, SHALL immediately force the following: state=IDLE, acc=0, count=0, x=0, out_valid=0, in_ready=1 (IDLE).
REQ-028 On reset release, no partial dot product SHALL be resumed; the next accepted beat is treated as a first beat.

Verification (LEN=4)
REQ-029 Four beats of a=0x0100, w=0x0100, with bias=0 -> x=0x40800000 (4.0), out_valid one cycle after the 4th beat.
REQ-030 bias=0xFFF90000 with a=0 on all beats -> x=0xC0E00000 (-7.0); a=0x0080, w=0x0100 on beat 1 with the rest zero and bias=0 -> x=0x3F000000 (0.5).
REQ-031 a=0x0001, w=0x0001 on one beat, the rest zero, bias=0 -> x=0x37800000 (2^-16); all zero -> x=0x00000000.
REQ-032 Beats separated by in_valid=0 gaps of 0-3 cycles -> the same x as the back-to-back case; count unaffected by the gaps.
REQ-033 out_ready=0 held for 5 cycles in OUT with in_valid=1 -> x stable, in_ready=0, no beat consumed; out_ready=1 -> out_valid falls and in_ready=1 the next cycle.
REQ-034 rst_n pulsed low after 2 of 4 beats -> out_valid=0 and x=0 immediately; a following full 4-beat sequence yields the correct result with no contribution from the pre-reset beats.
